face_draw_sched: RTL and testbench

- Arbitrates between two requesters (game-result display and board/erase logic) that share the single 16x16 face-sprite drawer.
- Sequences the drawer's `plot` enable for one full sprite and generates the VGA write enable aligned to the drawer's output latency.
- Sits between the game FSM and the face drawer / VGA adapter.
- Drawer contract: counters reset while `plot`=0; one pixel per cycle while `plot`=1; pixel valid PIPE_LAT cycles after the plot cycle.

---
 rtl/face_draw_sched.sv | 170 +++++++++++++++++
 tb/tb_face_draw_sched.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/face_draw_sched.sv
// Shares one 16x16 face-sprite drawer between two requesters: round-robin grant,
// plot sequencing for a full sprite, and a write enable aligned to the drawer latency.
module face_draw_sched #(
  parameter int PIXELS   = 256,
  parameter int PIPE_LAT = 2,
  parameter int GAP      = 2
) (
  input  logic       iClock,
  input  logic       iResetn,
  input  logic       iReq0Valid,
  input  logic [7:0] iReq0X,
  input  logic [6:0] iReq0Y,
  input  logic       iReq0Face,
  output logic       oReq0Ready,
  input  logic       iReq1Valid,
  input  logic [7:0] iReq1X,
  input  logic [6:0] iReq1Y,
  input  logic       iReq1Face,
  output logic       oReq1Ready,
  output logic       oPlot,
  output logic [7:0] oXCoord,
  output logic [6:0] oYCoord,
  output logic       oFace,
  output logic       oWriteEn,
  output logic       oBusy,
  output logic       oDone,
  output logic       oDoneId
);

  localparam int CNT_W = 9;
  localparam logic [CNT_W-1:0] DRAW_LAST = CNT_W'(PIXELS + PIPE_LAT - 1);
  localparam logic [CNT_W-1:0] WE_FIRST  = CNT_W'(PIPE_LAT);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             rr_reg, rr_next;
  logic             id_reg, id_next;
  logic [7:0]       x_reg, x_next;
  logic [6:0]       y_reg, y_next;
  logic             face_reg, face_next;
  logic             we_reg, we_next;

  logic [1:0] req_valid;
  logic [7:0] req_x [2];
  logic [6:0] req_y [2];
  logic [1:0] req_face;
  logic [1:0] grant;
  logic       winner;
  logic       accept;
  logic       done_pulse;

  assign req_valid = {iReq1Valid, iReq0Valid};
  assign req_face  = {iReq1Face, iReq0Face};
  assign req_x[0]  = iReq0X;
  assign req_x[1]  = iReq1X;
  assign req_y[0]  = iReq0Y;
  assign req_y[1]  = iReq1Y;

  // Under contention the requester that did not win last time goes next.
  always_comb begin
    winner = 1'b0;
    if (req_valid == 2'b11)
      winner = ~rr_reg;
    else
      winner = req_valid[1];
  end

  // Ready is gated by reset so a request coinciding with reset never looks accepted.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_grant
      assign grant[gi] = iResetn && (state_reg == S_IDLE) && req_valid[gi]
                         && (winner == 1'(gi));
    end
  endgenerate

  assign oReq0Ready = grant[0];
  assign oReq1Ready = grant[1];
  assign accept     = |grant;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rr_next    = rr_reg;
    id_next    = id_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    face_next  = face_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          state_next = S_DRAW;
          cnt_next   = '0;
          rr_next    = winner;
          id_next    = winner;
          x_next     = req_x[winner];
          y_next     = req_y[winner];
          face_next  = req_face[winner];
        end
      end
      S_DRAW: begin
        if (cnt_reg == DRAW_LAST) begin
          state_next = S_GAP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_reg == GAP_LAST) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Write enable is computed from the next counter so the register lines up
  // with the drawer's pixel output PIPE_LAT cycles after each plot cycle.
  always_comb begin
    we_next = (state_next == S_DRAW) && (cnt_next >= WE_FIRST) && (cnt_next <= DRAW_LAST);
  end

  always_ff @(posedge iClock) begin
    if (!iResetn) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      rr_reg    <= 1'b1;
      id_reg    <= 1'b0;
      x_reg     <= '0;
      y_reg     <= '0;
      face_reg  <= 1'b0;
      we_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rr_reg    <= rr_next;
      id_reg    <= id_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      face_reg  <= face_next;
      we_reg    <= we_next;
    end
  end

  assign done_pulse = (state_reg == S_GAP) && (cnt_reg == '0);

  assign oPlot    = (state_reg == S_DRAW);
  assign oBusy    = (state_reg != S_IDLE);
  assign oWriteEn = we_reg;
  assign oDone    = done_pulse;
  assign oDoneId  = done_pulse & id_reg;
  assign oXCoord  = x_reg;
  assign oYCoord  = y_reg;
  assign oFace    = face_reg;

endmodule

// File: tb/tb_face_draw_sched.sv
// Randomized bench for face_draw_sched: a high-level model of the grant order and
// of the per-job waveform shape (plot, write, done, busy) checks every job.
module tb_face_draw_sched;

  localparam int PIXELS   = 256;
  localparam int PIPE_LAT = 2;
  localparam int GAP      = 2;
  // Samples from the accept edge up to and including the first IDLE cycle.
  localparam int SPAN     = 1 + PIXELS + PIPE_LAT + GAP;

  logic       iClock;
  logic       iResetn;
  logic       iReq0Valid, iReq1Valid;
  logic [7:0] iReq0X, iReq1X;
  logic [6:0] iReq0Y, iReq1Y;
  logic       iReq0Face, iReq1Face;
  logic       oReq0Ready, oReq1Ready;
  logic       oPlot;
  logic [7:0] oXCoord;
  logic [6:0] oYCoord;
  logic       oFace;
  logic       oWriteEn;
  logic       oBusy;
  logic       oDone;
  logic       oDoneId;

  face_draw_sched #(.PIXELS(PIXELS), .PIPE_LAT(PIPE_LAT), .GAP(GAP)) dut (
    .iClock    (iClock),
    .iResetn   (iResetn),
    .iReq0Valid(iReq0Valid),
    .iReq0X    (iReq0X),
    .iReq0Y    (iReq0Y),
    .iReq0Face (iReq0Face),
    .oReq0Ready(oReq0Ready),
    .iReq1Valid(iReq1Valid),
    .iReq1X    (iReq1X),
    .iReq1Y    (iReq1Y),
    .iReq1Face (iReq1Face),
    .oReq1Ready(oReq1Ready),
    .oPlot     (oPlot),
    .oXCoord   (oXCoord),
    .oYCoord   (oYCoord),
    .oFace     (oFace),
    .oWriteEn  (oWriteEn),
    .oBusy     (oBusy),
    .oDone     (oDone),
    .oDoneId   (oDoneId)
  );

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  int cyc = 0;
  always @(posedge iClock) cyc <= cyc + 1;

  int   checks   = 0;
  int   failures = 0;
  logic model_rr;

  // Sample readies mid-cycle, then let the edge happen (accept if granted).
  task automatic offer(output logic r0, output logic r1);
    #1;
    r0 = oReq0Ready;
    r1 = oReq1Ready;
    @(posedge iClock);
    #1;
  endtask

  task automatic do_reset();
    iResetn = 1'b0;
    @(posedge iClock);
    #1;
    iResetn  = 1'b1;
    model_rr = 1'b1;
  endtask

  task automatic set_req(input logic id, input logic v, input logic [7:0] x,
                         input logic [6:0] y, input logic f);
    if (id) begin
      iReq1Valid = v; iReq1X = x; iReq1Y = y; iReq1Face = f;
    end else begin
      iReq0Valid = v; iReq0X = x; iReq0Y = y; iReq0Face = f;
    end
  endtask

  // Watches one job from the sample after its accept edge to the first IDLE
  // sample; optionally inverts the requester inputs mid-job at tamper_n.
  task automatic run_job(input logic exp_id, input logic [7:0] ex, input logic [6:0] ey,
                         input logic ef, input int tamper_n, input string tag,
                         output int first_plot, output int last_plot);
    int   plot_cnt  = 0;
    int   we_cnt    = 0;
    int   first_we  = 0;
    int   last_we   = 0;
    int   done_cnt  = 0;
    int   done_n    = 0;
    int   busy_last = 0;
    int   bad_coord = 0;
    int   bad_rdy   = 0;
    logic done_id   = 1'b0;
    first_plot = 0;
    last_plot  = 0;
    for (int n = 1; n <= SPAN; n++) begin
      if (n > 1) begin
        @(posedge iClock);
        #1;
      end
      if (oPlot) begin
        plot_cnt++;
        if (first_plot == 0) first_plot = n;
        last_plot = n;
      end
      if (oWriteEn) begin
        we_cnt++;
        if (first_we == 0) first_we = n;
        last_we = n;
      end
      if (oDone) begin
        done_cnt++;
        done_n  = n;
        done_id = oDoneId;
      end
      if (oBusy) begin
        busy_last = n;
        if (oXCoord !== ex || oYCoord !== ey || oFace !== ef) bad_coord++;
        if (oReq0Ready || oReq1Ready) bad_rdy++;
      end
      if (n == tamper_n) begin
        iReq0X = ~iReq0X; iReq0Y = ~iReq0Y; iReq0Face = ~iReq0Face;
        iReq1X = ~iReq1X; iReq1Y = ~iReq1Y; iReq1Face = ~iReq1Face;
      end
    end
    $display("job %s: id=%0d x=%0d y=%0d face=%0d plots=%0d writes=%0d done_at=%0d",
             tag, exp_id, ex, ey, ef, plot_cnt, we_cnt, done_n);
    checks++;
    if (plot_cnt !== PIXELS + PIPE_LAT || first_plot !== 1 || last_plot !== PIXELS + PIPE_LAT) begin
      failures++;
      $display("FAIL %s plot: got cnt=%0d first=%0d last=%0d, want cnt=%0d first=1 last=%0d",
               tag, plot_cnt, first_plot, last_plot, PIXELS + PIPE_LAT, PIXELS + PIPE_LAT);
    end
    checks++;
    if (we_cnt !== PIXELS || first_we !== 1 + PIPE_LAT || last_we !== PIXELS + PIPE_LAT) begin
      failures++;
      $display("FAIL %s write_en: got cnt=%0d first=%0d last=%0d, want cnt=%0d first=%0d last=%0d",
               tag, we_cnt, first_we, last_we, PIXELS, 1 + PIPE_LAT, PIXELS + PIPE_LAT);
    end
    checks++;
    if (done_cnt !== 1 || done_n !== PIXELS + PIPE_LAT + 1 || done_id !== exp_id) begin
      failures++;
      $display("FAIL %s done: got pulses=%0d at=%0d id=%0d, want pulses=1 at=%0d id=%0d",
               tag, done_cnt, done_n, done_id, PIXELS + PIPE_LAT + 1, exp_id);
    end
    checks++;
    if (busy_last !== PIXELS + PIPE_LAT + GAP) begin
      failures++;
      $display("FAIL %s busy: got last busy sample=%0d, want %0d", tag, busy_last, PIXELS + PIPE_LAT + GAP);
    end
    checks++;
    if (bad_coord !== 0 || bad_rdy !== 0) begin
      failures++;
      $display("FAIL %s hold: got coord_errs=%0d ready_while_busy=%0d, want 0 and 0 (x=%0d y=%0d face=%0d)",
               tag, bad_coord, bad_rdy, ex, ey, ef);
    end
  endtask

  task automatic test_reset();
    iResetn = 1'b0;
    set_req(1'b0, 1'b0, 8'd0, 7'd0, 1'b0);
    set_req(1'b1, 1'b0, 8'd0, 7'd0, 1'b0);
    repeat (3) @(posedge iClock);
    #1;
    checks++;
    if ({oReq0Ready, oReq1Ready, oPlot, oXCoord, oYCoord, oFace, oWriteEn, oBusy, oDone, oDoneId} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got plot=%0b x=%0d y=%0d face=%0b we=%0b busy=%0b done=%0b id=%0b, want all 0",
               oPlot, oXCoord, oYCoord, oFace, oWriteEn, oBusy, oDone, oDoneId);
    end
    iReq0Valid = 1'b1;
    iReq1Valid = 1'b1;
    #1;
    checks++;
    if ({oReq1Ready, oReq0Ready} !== 2'b00) begin
      failures++;
      $display("FAIL reset_ready: got ready={%0b,%0b}, want 00", oReq1Ready, oReq0Ready);
    end
    @(posedge iClock);
    #1;
    checks++;
    if (oBusy !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_accept: got busy=%0b, want 0", oBusy);
    end
    iReq0Valid = 1'b0;
    iReq1Valid = 1'b0;
    iResetn    = 1'b1;
    model_rr   = 1'b1;
    @(posedge iClock);
    #1;
  endtask

  task automatic test_single();
    logic r0, r1;
    logic id;
    logic [7:0] x;
    logic [6:0] y;
    logic f;
    int fp, lp;
    do_reset();
    set_req(1'b0, 1'b1, 8'd40, 7'd30, 1'b0);
    offer(r0, r1);
    checks++;
    if ({r1, r0} !== 2'b01) begin
      failures++;
      $display("FAIL single_grant: got ready={%0b,%0b}, want 01", r1, r0);
    end
    iReq0Valid = 1'b0;
    model_rr   = 1'b0;
    run_job(1'b0, 8'd40, 7'd30, 1'b0, 0, "single", fp, lp);
    for (int k = 0; k < 3; k++) begin
      id = 1'($urandom_range(0, 1));
      x  = 8'($urandom);
      y  = 7'($urandom);
      f  = 1'($urandom);
      set_req(id, 1'b1, x, y, f);
      offer(r0, r1);
      checks++;
      if ({r1, r0} !== (id ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL lone_grant%0d: got ready={%0b,%0b}, want id %0d", k, r1, r0, id);
      end
      set_req(id, 1'b0, x, y, f);
      model_rr = id;
      run_job(id, x, y, f, 0, $sformatf("lone%0d", k), fp, lp);
    end
  endtask

  task automatic test_contention();
    logic r0, r1;
    logic exp_id;
    logic [1:0] v;
    logic [7:0] x0, x1;
    logic [6:0] y0, y1;
    logic f0, f1;
    int fp, lp;
    do_reset();
    y0 = 7'($urandom); y1 = 7'($urandom);
    f0 = 1'($urandom); f1 = 1'($urandom);
    set_req(1'b0, 1'b1, 8'd10, y0, f0);
    set_req(1'b1, 1'b1, 8'd100, y1, f1);
    for (int k = 0; k < 4; k++) begin
      exp_id = ~model_rr;
      offer(r0, r1);
      checks++;
      if ({r1, r0} !== (exp_id ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL contend_grant%0d: got ready={%0b,%0b}, want id %0d", k, r1, r0, exp_id);
      end
      model_rr = exp_id;
      run_job(exp_id, exp_id ? 8'd100 : 8'd10, exp_id ? y1 : y0, exp_id ? f1 : f0, 0,
              $sformatf("contend%0d", k), fp, lp);
    end
    for (int k = 0; k < 5; k++) begin
      v  = 2'($urandom_range(1, 3));
      x0 = 8'($urandom); x1 = 8'($urandom);
      y0 = 7'($urandom); y1 = 7'($urandom);
      f0 = 1'($urandom); f1 = 1'($urandom);
      set_req(1'b0, v[0], x0, y0, f0);
      set_req(1'b1, v[1], x1, y1, f1);
      exp_id = (v == 2'b11) ? ~model_rr : v[1];
      offer(r0, r1);
      checks++;
      if ({r1, r0} !== (exp_id ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL rand_grant%0d: got ready={%0b,%0b}, want id %0d (valid=%b)", k, r1, r0, exp_id, v);
      end
      iReq0Valid = 1'b0;
      iReq1Valid = 1'b0;
      model_rr   = exp_id;
      run_job(exp_id, exp_id ? x1 : x0, exp_id ? y1 : y0, exp_id ? f1 : f0, 0,
              $sformatf("rand%0d", k), fp, lp);
    end
  endtask

  task automatic test_hold();
    logic r0, r1;
    logic [7:0] x;
    logic [6:0] y;
    logic f;
    int fp, lp;
    x = 8'($urandom); y = 7'($urandom); f = 1'($urandom);
    iReq1Valid = 1'b0;
    set_req(1'b0, 1'b1, x, y, f);
    offer(r0, r1);
    checks++;
    if ({r1, r0} !== 2'b01) begin
      failures++;
      $display("FAIL hold_grant: got ready={%0b,%0b}, want 01", r1, r0);
    end
    iReq0Valid = 1'b0;
    model_rr   = 1'b0;
    run_job(1'b0, x, y, f, 100, "hold_old", fp, lp);
    iReq0Valid = 1'b1;
    offer(r0, r1);
    checks++;
    if ({r1, r0} !== 2'b01) begin
      failures++;
      $display("FAIL hold_regrant: got ready={%0b,%0b}, want 01", r1, r0);
    end
    iReq0Valid = 1'b0;
    run_job(1'b0, ~x, ~y, ~f, 0, "hold_new", fp, lp);
  endtask

  task automatic test_reset_mid();
    logic r0, r1;
    logic [7:0] x;
    logic [6:0] y;
    int done_seen = 0;
    int fp, lp;
    do_reset();
    x = 8'($urandom); y = 7'($urandom);
    set_req(1'b0, 1'b1, x, y, 1'b1);
    offer(r0, r1);
    iReq0Valid = 1'b0;
    // Sample n carries counter n-1, so n=101 is DRAW counter 100.
    for (int n = 1; n <= 101; n++) begin
      if (n > 1) begin
        @(posedge iClock);
        #1;
      end
      if (oDone) done_seen++;
    end
    checks++;
    if (oPlot !== 1'b1) begin
      failures++;
      $display("FAIL mid_in_draw: got plot=%0b at counter 100, want 1", oPlot);
    end
    iResetn    = 1'b0;
    iReq0Valid = 1'b1;
    iReq1Valid = 1'b1;
    @(posedge iClock);
    #1;
    if (oDone) done_seen++;
    checks++;
    if ({oPlot, oWriteEn, oBusy, oDone, oDoneId, oXCoord, oYCoord, oFace} !== '0 || done_seen !== 0) begin
      failures++;
      $display("FAIL mid_reset: got plot=%0b we=%0b busy=%0b done=%0b x=%0d y=%0d dones=%0d, want all 0",
               oPlot, oWriteEn, oBusy, oDone, oXCoord, oYCoord, done_seen);
    end
    iResetn  = 1'b1;
    model_rr = 1'b1;
    offer(r0, r1);
    checks++;
    if ({r1, r0} !== 2'b01) begin
      failures++;
      $display("FAIL post_reset_grant: got ready={%0b,%0b}, want 01", r1, r0);
    end
    iReq0Valid = 1'b0;
    iReq1Valid = 1'b0;
    model_rr   = 1'b0;
    run_job(1'b0, x, y, 1'b1, 0, "post_reset", fp, lp);
  endtask

  task automatic test_back_to_back();
    logic r0, r1;
    logic [7:0] x;
    logic [6:0] y;
    int acc1, acc2, fp1, lp1, fp2, lp2;
    x = 8'($urandom); y = 7'($urandom);
    iReq0Valid = 1'b0;
    set_req(1'b1, 1'b1, x, y, 1'b1);
    offer(r0, r1);
    acc1 = cyc;
    checks++;
    if ({r1, r0} !== 2'b10) begin
      failures++;
      $display("FAIL b2b_grant0: got ready={%0b,%0b}, want 10", r1, r0);
    end
    iReq1Face = 1'b0;
    model_rr  = 1'b1;
    run_job(1'b1, x, y, 1'b1, 0, "b2b_first", fp1, lp1);
    offer(r0, r1);
    acc2 = cyc;
    checks++;
    if ({r1, r0} !== 2'b10) begin
      failures++;
      $display("FAIL b2b_grant1: got ready={%0b,%0b} on first IDLE, want 10", r1, r0);
    end
    iReq1Valid = 1'b0;
    run_job(1'b1, x, y, 1'b0, 0, "b2b_second", fp2, lp2);
    checks++;
    if (acc2 - acc1 !== SPAN) begin
      failures++;
      $display("FAIL b2b_spacing: got %0d cycles between accepts, want %0d", acc2 - acc1, SPAN);
    end
    // Plot stays low for the GAP cycles plus the IDLE cycle that accepts.
    checks++;
    if ((SPAN - lp1) + (fp2 - 1) !== GAP + 1) begin
      failures++;
      $display("FAIL b2b_plot_gap: got %0d low cycles, want %0d", (SPAN - lp1) + (fp2 - 1), GAP + 1);
    end
  endtask

  initial begin
    model_rr = 1'b1;
    test_reset();
    test_single();
    test_contention();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
